// File: rtl/ngv_lcd_bridge_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package : ngv_pkg                                                        |
// | Purpose : Shared types and helpers for the NGV LCD write bridge:         |
// |           sequencer state encoding, FIFO entry width, clog2 helper.      |
// | Ports   : none (package)                                                 |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
package ngv_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } lcd_state_t;

  localparam int HOST_DW = 16;
  // A FIFO entry is {rs, data}.
  localparam int ENTRY_W = HOST_DW + 1;

  // Smallest n with 2**n >= value.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ngv_lcd_bridge_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface : ngv_lcd_bridge_if                                            |
// | Purpose   : Host handshake, sideband and LCD bus signals of the bridge.  |
// | Signals   : in_valid/in_ready/in_rs/in_data  host write handshake        |
// |             sblk/srst -> blk/rst               registered sidebands      |
// |             cs/rs/wr/rd/data                   8080-style LCD bus        |
// |             busy/level                         status                    |
// | Modports  : slave (bridge side), master (host/LCD model side)            |
// | Rev       : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
interface ngv_lcd_bridge_if #(
  parameter int DW    = 16,
  parameter int BUS_W = 16,
  parameter int DEPTH = 16
);
  import ngv_pkg::*;

  localparam int LW = clog2(DEPTH + 1);

  logic             in_valid;
  logic             in_ready;
  logic             in_rs;
  logic [DW-1:0]    in_data;
  logic             sblk;
  logic             srst;
  logic             blk;
  logic             rst;
  logic             cs;
  logic             rs;
  logic             wr;
  logic             rd;
  logic [BUS_W-1:0] data;
  logic             busy;
  logic [LW-1:0]    level;

  modport slave (
    input  in_valid, in_rs, in_data, sblk, srst,
    output in_ready, blk, rst, cs, rs, wr, rd, data, busy, level
  );

  modport master (
    output in_valid, in_rs, in_data, sblk, srst,
    input  in_ready, blk, rst, cs, rs, wr, rd, data, busy, level
  );

endinterface
`default_nettype wire

// File: rtl/ngv_lcd_bridge_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : ngv_sync_fifo                                                  |
// | Purpose : Single-clock FIFO with registered read data (dout updates only |
// |           on an honoured pop and otherwise holds).                       |
// | Ports   : clk_i, rst_i         clock, synchronous active-high reset      |
// |           push_i, din_i        write request / data (ignored when full)  |
// |           pop_i, dout_o        read request / registered read data       |
// |           full_o, empty_o      status                                    |
// |           level_o              occupancy, 0..DEPTH                       |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module ngv_sync_fifo
  import ngv_pkg::*;
#(
  parameter int DW    = ENTRY_W,
  parameter int DEPTH = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [DW-1:0]              din_i,
  output logic [DW-1:0]              dout_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [clog2(DEPTH+1)-1:0]  level_o
);

  localparam int AW = clog2(DEPTH);
  localparam int LW = clog2(DEPTH + 1);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q;
  logic [AW-1:0] rptr_q;
  logic [LW-1:0] level_q;
  logic [DW-1:0] dout_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign dout_o  = dout_q;
  assign level_o = level_q;

  // Storage carries no reset; only pointers and occupancy define contents.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= din_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      dout_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop) begin
        dout_q <= mem_q[rptr_q];
        rptr_q <= rptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/ngv_lcd_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : ngv_lcd_bridge                                                 |
// | Purpose : Buffered 8080-style LCD write bridge. Host {rs,data} words are |
// |           queued in a FIFO and replayed with programmable setup, strobe  |
// |           and hold timing; optional 16->8 narrowing (high byte first).   |
// | Ports   : pclk, prst   clock, synchronous active-high reset              |
// |           bus          ngv_lcd_bridge_if.slave (host handshake, LCD bus, |
// |                        blk/rst sidebands, busy/level status)             |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module ngv_lcd_bridge
  import ngv_pkg::*;
#(
  parameter int DW      = HOST_DW,
  parameter int BUS_W   = 16,
  parameter int DEPTH   = 16,
  parameter int T_SETUP = 1,
  parameter int T_WR    = 2,
  parameter int T_HOLD  = 1
) (
  input  logic              pclk,
  input  logic              prst,
  ngv_lcd_bridge_if.slave   bus
);

  localparam int EW   = DW + 1;
  localparam int LW   = clog2(DEPTH + 1);
  localparam int TMAX = (T_SETUP > T_WR) ? ((T_SETUP > T_HOLD) ? T_SETUP : T_HOLD)
                                         : ((T_WR > T_HOLD) ? T_WR : T_HOLD);
  localparam int CW   = clog2(TMAX + 1);

  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [LW-1:0] fifo_level;
  logic [EW-1:0] entry;

  lcd_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          hi_done_q, hi_done_d;
  logic          cs_q, cs_d;
  logic          wr_q, wr_d;
  logic          blk_q;
  logic          rst_q;

  assign fifo_push = bus.in_valid && bus.in_ready;

  // The FIFO's registered read port doubles as the entry latch: it only
  // changes on a pop, so rs/data stay stable for the whole beat.
  ngv_sync_fifo #(
    .DW    (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (pclk),
    .rst_i   (prst),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .din_i   ({bus.in_rs, bus.in_data}),
    .dout_o  (entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  always_ff @(posedge pclk) begin
    if (prst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hi_done_q <= 1'b0;
      cs_q      <= 1'b1;
      wr_q      <= 1'b1;
      blk_q     <= 1'b0;
      rst_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_done_q <= hi_done_d;
      cs_q      <= cs_d;
      wr_q      <= wr_d;
      blk_q     <= bus.sblk;
      rst_q     <= bus.srst;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    hi_done_d = hi_done_q;
    cs_d      = cs_q;
    wr_d      = wr_q;
    fifo_pop  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          state_d   = SETUP;
          cs_d      = 1'b0;
          hi_done_d = 1'b0;
        end
      end
      SETUP: begin
        if (cnt_q == CW'(T_SETUP - 1)) begin
          state_d = STROBE;
          cnt_d   = '0;
          wr_d    = 1'b0;
        end
      end
      STROBE: begin
        if (cnt_q == CW'(T_WR - 1)) begin
          state_d = HOLD;
          cnt_d   = '0;
          wr_d    = 1'b1;
        end
      end
      HOLD: begin
        if (cnt_q == CW'(T_HOLD - 1)) begin
          cnt_d = '0;
          if ((BUS_W == 8) && !hi_done_q) begin
            // Second beat of a narrowed word reuses the latched entry.
            state_d   = SETUP;
            hi_done_d = 1'b1;
          end else if (!fifo_empty) begin
            // Burst: chain straight into the next word with cs kept low.
            fifo_pop  = 1'b1;
            state_d   = SETUP;
            hi_done_d = 1'b0;
          end else begin
            state_d = IDLE;
            cs_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cs_d    = 1'b1;
        wr_d    = 1'b1;
      end
    endcase
  end

  generate
    if (BUS_W == 8) begin : g_bus8
      assign bus.data = hi_done_q ? entry[7:0] : entry[15:8];
    end else begin : g_bus16
      assign bus.data = entry[BUS_W-1:0];
    end
  endgenerate

  assign bus.rs       = entry[DW];
  assign bus.cs       = cs_q;
  assign bus.wr       = wr_q;
  assign bus.rd       = 1'b1;
  assign bus.blk      = blk_q;
  assign bus.rst      = rst_q;
  assign bus.in_ready = !fifo_full && !prst;
  assign bus.busy     = !fifo_empty || (state_q != IDLE);
  assign bus.level    = fifo_level;

endmodule
`default_nettype wire

// File: doc/ngv_lcd_bridge.md
Name: ngv_lcd_bridge

Overview:
Buffered, timing-programmable 8080-style LCD write bridge. It is the successor to the plain LCD pass-through in the NGV converter.
- Host writes {rs, data} words through a valid/ready handshake into a FIFO.
- An output sequencer replays each entry on the LCD bus with parametrised setup, strobe and hold cycles.
- Optional 16-to-8 bus narrowing sends two beats, high byte first.
- Backlight and LCD reset are registered pass-throughs.

Parameters:
DW, 16, host data width
BUS_W, 16, LCD bus width; legal values 16 or 8 (8 requires DW=16)
DEPTH, 16, FIFO entries; power of 2, minimum 2
T_SETUP, 1, cycles with cs/rs/data valid before wr falls; minimum 1
T_WR, 2, cycles wr held low; minimum 1
T_HOLD, 1, cycles data held after wr rises; minimum 1

Ports:
pclk  in  1  single clock
prst  in  1  reset, synchronous, active-high
in_valid  in  1  host word valid
in_ready  out  1  FIFO can accept
in_rs  in  1  0=command, 1=data
in_data  in  DW  host word
sblk  in  1  backlight request
srst  in  1  LCD reset request (active-low, as LCD)
blk  out  1  registered sblk
rst  out  1  registered srst
cs  out  1  chip select, active-low
rs  out  1  register select
wr  out  1  write strobe, active-low
rd  out  1  read strobe; held 1 (write-only bridge)
data  out  BUS_W  LCD bus
busy  out  1  FIFO non-empty or FSM not IDLE
level  out  clog2(DEPTH+1)  FIFO occupancy

Behaviour:
- Reset values, applied at the first pclk edge with prst=1:
  - cs=1, wr=1, rd=1, rs=0, data=0
  - blk=0, rst=0 (LCD held in reset)
  - busy=0, level=0, in_ready=0 while prst=1
  - FSM=IDLE
- FIFO:
  - Push on in_valid & in_ready; in_ready = !full.
  - Push and pop in the same cycle are both honoured; level is unchanged.
  - No bypass path: a word pushed into an empty FIFO at edge k is seen by the FSM at edge k+1.
- FSM states: IDLE, SETUP, STROBE, HOLD. Internal counter cnt; beat flag hi_done (BUS_W=8 only).
- IDLE:
  - If the FIFO is non-empty: pop, latch the entry, and go to SETUP.
  - On entering SETUP: cs=0, rs=entry.rs, data=entry.data (BUS_W=16) or entry.data[15:8] (BUS_W=8).
  - Latency from an accepted push into an empty, idle bridge to cs falling is 2 cycles.
- SETUP: T_SETUP cycles, then STROBE with wr=0.
- STROBE: T_WR cycles, then HOLD with wr=1; data and rs are unchanged.
- HOLD: T_HOLD cycles, then:
  - BUS_W=8 and high beat just sent: SETUP with data=entry.data[7:0]. cs stays 0; no pop.
  - Else, FIFO non-empty: pop the next entry and go to SETUP. cs stays 0 (burst).
  - Else: IDLE with cs=1. data holds its last value.
- Per-beat cycle count = T_SETUP+T_WR+T_HOLD. With the defaults, one 16-bit word = 4 cycles.
- blk and rst are 1-cycle registered copies of sblk and srst, independent of the FSM.
- Reset mid-operation:
  - FIFO is flushed and the FSM returns to IDLE.
  - wr/cs return to 1 at that edge; no strobe is completed.
  - Words accepted before reset are lost.
- Full FIFO: in_ready=0 at level=DEPTH. It reasserts the cycle after a pop.
- rd is never driven low.

Decomposition:
- ngv_pkg holds:
  - the lcd_state_t enum (IDLE, SETUP, STROBE, HOLD)
  - the entry width constant ENTRY_W = DW+1
  - a clog2 function
- Sub-module ngv_sync_fifo (DW, DEPTH):
  - ports: push/pop/din/dout/full/empty/level
  - synchronous reset, registered dout on pop

Test Plan:
- Single word, defaults: push rs=1, data=16'hA5C3 at cycle 0 -> cs=0 at cycle 2; wr=0 at cycles 3-4; data=16'hA5C3 throughout; cs=1 at cycle 6.
- BUS_W=8: push rs=0, data=16'h1234 -> beat 1 data=8'h12, beat 2 data=8'h34; two wr pulses; cs low continuously across both beats; rs=0.
- Burst of 5 words pushed back-to-back -> cs stays low across all 5; 5 wr pulses, 4 cycles apart; words emitted in order; busy falls after the last HOLD.
- Backpressure, DEPTH=4, in_valid held high with the FSM stalled mid-beat -> in_ready=0 once level=4; no word dropped or duplicated; all words later emitted in order.
- prst asserted during STROBE -> next edge wr=1, cs=1, level=0, rst=0; the following push is emitted normally.
- T_SETUP=2, T_WR=3, T_HOLD=2 -> wr low for exactly 3 cycles; 7-cycle beat period; blk/rst follow sblk/srst with 1-cycle delay.
